win33_tile_ctrl: RTL and testbench

Control and data-marshalling front/back end for the Winograd F(2x2,3x3) engine (win33). It walks a feature map in overlapping 4x4 input tiles with stride 2. For each tile it drives act1..act4/kernel1..kernel3 and a one-cycle enable, waits for end_signal_win33, then unpacks f_tmp into four 2x2 output-pixel writes. One start produces a full valid-mode 3x3 convolution of one channel.

---
 rtl/win33_tile_ctrl_if.sv | 40 ++++
 rtl/win33_tile_ctrl.sv | 137 +++++++++++++
 tb/tb_win33_tile_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/win33_tile_ctrl_if.sv
// Bundle between the tile controller and its environment: start/kernel config,
// feature-map read port, Winograd engine operands/result, and output write port.
interface win33_tile_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [1:0]        bitwidth_in;
    logic [143:0]      kernel_in;
    logic              fm_rd;
    logic [ADDR_W-1:0] fm_addr;
    logic [15:0]       fm_rdata;
    logic [63:0]       act1;
    logic [63:0]       act2;
    logic [63:0]       act3;
    logic [63:0]       act4;
    logic [47:0]       kernel1;
    logic [47:0]       kernel2;
    logic [47:0]       kernel3;
    logic [1:0]        bitwidth;
    logic              enable;
    logic [127:0]      f_tmp;
    logic              end_signal_win33;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_data;
    logic              busy;
    logic              done;

    modport master (
        input  start, bitwidth_in, kernel_in, fm_rdata, f_tmp, end_signal_win33,
        output fm_rd, fm_addr, act1, act2, act3, act4, kernel1, kernel2, kernel3,
               bitwidth, enable, out_we, out_addr, out_data, busy, done
    );

    modport slave (
        output start, bitwidth_in, kernel_in, fm_rdata, f_tmp, end_signal_win33,
        input  fm_rd, fm_addr, act1, act2, act3, act4, kernel1, kernel2, kernel3,
               bitwidth, enable, out_we, out_addr, out_data, busy, done
    );
endinterface

// File: rtl/win33_tile_ctrl.sv
// Walks the map in 4x4 stride-2 tiles feeding win33; per tile 16+1+1+L+4+1 cycles.
// No backpressure: fm reads are fixed-latency, engine result wait is unbounded.
module win33_tile_ctrl #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    win33_tile_ctrl_if.master  bus
);
    localparam int NTX = (IMG_W - 2) / 2;
    localparam int NTY = (IMG_H - 2) / 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CAPT  = 3'd2;
    localparam logic [2:0] S_FIRE  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_NEXT  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    logic [2:0]             state;
    logic [3:0]             k;
    logic [3:0]             k_d;
    logic                   rd_d;
    logic [ADDR_W-1:0]      tx;
    logic [ADDR_W-1:0]      ty;
    logic [1:0]             wcnt;
    logic [3:0][31:0]       f_reg;
    logic [3:0][3:0][15:0]  act_r;
    logic [47:0]            kern1_r;
    logic [47:0]            kern2_r;
    logic [47:0]            kern3_r;
    logic [1:0]             bw_r;

    logic [ADDR_W-1:0]      fm_row;
    logic [ADDR_W-1:0]      fm_col;
    logic [ADDR_W-1:0]      wr_row;
    logic [ADDR_W-1:0]      wr_col;

    assign fm_row = (ty << 1) + ADDR_W'(k[3:2]);
    assign fm_col = (tx << 1) + ADDR_W'(k[1:0]);
    assign wr_row = (ty << 1) + ADDR_W'(wcnt[1]);
    assign wr_col = (tx << 1) + ADDR_W'(wcnt[0]);

    assign bus.fm_rd    = (state == S_FETCH);
    assign bus.fm_addr  = fm_row * ADDR_W'(IMG_W) + fm_col;
    assign bus.enable   = (state == S_FIRE);
    assign bus.out_we   = (state == S_WRITE);
    assign bus.out_addr = wr_row * ADDR_W'(IMG_W - 2) + wr_col;
    // f_reg[3] holds y00; inverting the 2-bit write count walks y00..y11
    assign bus.out_data = f_reg[~wcnt];
    assign bus.done     = (state == S_DONE);
    assign bus.busy     = (state != S_IDLE) && (state != S_DONE);
    assign bus.act1     = act_r[0];
    assign bus.act2     = act_r[1];
    assign bus.act3     = act_r[2];
    assign bus.act4     = act_r[3];
    assign bus.kernel1  = kern1_r;
    assign bus.kernel2  = kern2_r;
    assign bus.kernel3  = kern3_r;
    assign bus.bitwidth = bw_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            k       <= '0;
            k_d     <= '0;
            rd_d    <= 1'b0;
            tx      <= '0;
            ty      <= '0;
            wcnt    <= '0;
            f_reg   <= '0;
            act_r   <= '0;
            kern1_r <= '0;
            kern2_r <= '0;
            kern3_r <= '0;
            bw_r    <= '0;
        end else begin
            // read data lands one cycle after its strobe; column 0 sits in the MSBs
            rd_d <= (state == S_FETCH);
            k_d  <= k;
            if (rd_d) act_r[k_d[3:2]][~k_d[1:0]] <= bus.fm_rdata;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        kern1_r <= bus.kernel_in[143:96];
                        kern2_r <= bus.kernel_in[95:48];
                        kern3_r <= bus.kernel_in[47:0];
                        bw_r    <= bus.bitwidth_in;
                        k       <= '0;
                        tx      <= '0;
                        ty      <= '0;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    k <= k + 4'd1;
                    if (k == 4'd15) state <= S_CAPT;
                end
                S_CAPT: state <= S_FIRE;
                S_FIRE: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.end_signal_win33) begin
                        f_reg <= bus.f_tmp;
                        wcnt  <= '0;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wcnt <= wcnt + 2'd1;
                    if (wcnt == 2'd3) state <= S_NEXT;
                end
                S_NEXT: begin
                    state <= S_FETCH;
                    if (tx < ADDR_W'(NTX - 1)) begin
                        tx <= tx + 1'b1;
                    end else begin
                        tx <= '0;
                        if (ty < ADDR_W'(NTY - 1)) begin
                            ty <= ty + 1'b1;
                        end else begin
                            // park at the origin so an idle controller presents address 0
                            ty    <= '0;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_win33_tile_ctrl.sv
// Randomized bench for win33_tile_ctrl on an 8x8 map with a behavioural memory,
// engine model and write scoreboard derived directly from the tiling rules.
module tb_win33_tile_ctrl;
    localparam int W      = 8;
    localparam int H      = 8;
    localparam int AW     = 10;
    localparam int NTX    = (W - 2) / 2;
    localparam int NTY    = (H - 2) / 2;
    localparam int NOUT   = (W - 2) * (H - 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    win33_tile_ctrl_if #(.ADDR_W(AW)) bus ();

    win33_tile_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0]  mem [0:W*H-1];
    int           checks = 0;
    int           errors = 0;
    logic [143:0] kin;
    logic [1:0]   bw;
    int           qa[$];
    logic [31:0]  qd[$];
    int           written [0:NOUT-1];

    // feature-map memory: data valid exactly one cycle after the read strobe
    always @(posedge clk) begin
        if (bus.fm_rd) bus.fm_rdata <= mem[bus.fm_addr[5:0]];
        else           bus.fm_rdata <= 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_row(input int tx, input int ty, input int r);
        logic [63:0] v;
        for (int c = 0; c < 4; c++) v[63-16*c -: 16] = mem[(2*ty + r)*W + 2*tx + c];
        return v;
    endfunction

    function automatic logic [47:0] ref_kern(input logic [143:0] kv, input int row);
        logic [47:0] v;
        for (int j = 0; j < 3; j++) v[47-16*j -: 16] = kv[143-16*(3*row + j) -: 16];
        return v;
    endfunction

    task automatic chk_tile(input string pfx, input int t);
        int tx;
        int ty;
        tx = t % NTX;
        ty = t / NTX;
        chk({pfx, "_act1"}, bus.act1, ref_row(tx, ty, 0));
        chk({pfx, "_act2"}, bus.act2, ref_row(tx, ty, 1));
        chk({pfx, "_act3"}, bus.act3, ref_row(tx, ty, 2));
        chk({pfx, "_act4"}, bus.act4, ref_row(tx, ty, 3));
        chk({pfx, "_kernel1"}, bus.kernel1, ref_kern(kin, 0));
        chk({pfx, "_kernel2"}, bus.kernel2, ref_kern(kin, 1));
        chk({pfx, "_kernel3"}, bus.kernel3, ref_kern(kin, 2));
        chk({pfx, "_bitwidth"}, bus.bitwidth, bw);
    endtask

    task automatic fill_mem(input bit ramp);
        for (int a = 0; a < W*H; a++) mem[a] = ramp ? 16'(a) : 16'($urandom());
    endtask

    // delay<=0 selects a random engine latency per tile; abort_tile>=0 resets mid-fetch
    task automatic run_pass(input int delay, input bit const_mode, input bit robust,
                            input int abort_tile);
        int enables = 0;
        int writes = 0;
        int dones = 0;
        int rd_cnt = 0;
        int cd = 0;
        int cur = 0;
        int last_we = -10;
        int in_tile = 0;
        int t;
        int tx;
        int ty;
        int a;
        logic [31:0] d;
        logic [127:0] f;
        bit waiting = 1'b0;
        bit fin = 1'b0;

        for (int i = 0; i < NOUT; i++) written[i] = 0;
        qa.delete();
        qd.delete();
        kin[143:128] = 16'($urandom());
        for (int w = 0; w < 4; w++) kin[32*w +: 32] = $urandom();
        bw = 2'($urandom_range(0, 3));

        @(negedge clk);
        bus.start = 1'b1;
        bus.kernel_in = kin;
        bus.bitwidth_in = bw;

        for (int n = 1; n < 4000 && !fin; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.kernel_in = ~kin;
            bus.bitwidth_in = ~bw;
            bus.end_signal_win33 = 1'b0;

            if (waiting) begin
                cd--;
                if (cd == 0) begin
                    tx = cur % NTX;
                    ty = cur / NTX;
                    if (const_mode && cur == 4) f = {32'h11, 32'h22, 32'h33, 32'h44};
                    else f = {$urandom(), $urandom(), $urandom(), $urandom()};
                    bus.f_tmp = f;
                    bus.end_signal_win33 = 1'b1;
                    for (int i = 0; i < 2; i++)
                        for (int j = 0; j < 2; j++) begin
                            qa.push_back((2*ty + i)*(W - 2) + 2*tx + j);
                            qd.push_back(f[127-32*(2*i + j) -: 32]);
                        end
                    waiting = 1'b0;
                end
            end

            if (n == 1) begin
                chk("first_fm_rd", bus.fm_rd, 1);
                chk("first_fm_addr", bus.fm_addr, 0);
                chk("busy_after_start", bus.busy, 1);
            end

            if (bus.fm_rd) begin
                t = enables;
                tx = t % NTX;
                ty = t / NTX;
                chk("fm_addr", bus.fm_addr, (2*ty + rd_cnt/4)*W + 2*tx + rd_cnt%4);
                rd_cnt++;
                if (abort_tile == t && rd_cnt == 8) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    chk("abort_fm_rd", bus.fm_rd, 0);
                    chk("abort_busy", bus.busy, 0);
                    chk("abort_act", {bus.act1, bus.act2}, 0);
                    chk("abort_act_lo", {bus.act3, bus.act4}, 0);
                    chk("abort_kernel", {bus.kernel1, bus.kernel2, bus.kernel3}, 0);
                    chk("abort_bitwidth", bus.bitwidth, 0);
                    chk("abort_we", bus.out_we, 0);
                    rst_n = 1'b1;
                    return;
                end
                if (robust && t == 1 && rd_cnt == 5) begin
                    bus.start = 1'b1;
                    bus.end_signal_win33 = 1'b1;
                end
            end

            if (bus.enable) begin
                t = enables;
                chk("reads_per_tile", rd_cnt, 16);
                rd_cnt = 0;
                chk_tile("fire", t);
                chk("busy_fire", bus.busy, 1);
                if (const_mode && t == 0) begin
                    chk("enable_latency", n, 18);
                    chk("t0_act1", bus.act1, 64'h0000_0001_0002_0003);
                    chk("t0_act4", bus.act4, 64'h0018_0019_001A_001B);
                end
                enables++;
                cur = t;
                waiting = 1'b1;
                cd = (delay > 0) ? delay : int'($urandom_range(1, 8));
            end else if (waiting) begin
                chk_tile("hold", cur);
                chk("hold_enable", bus.enable, 0);
            end

            if (bus.out_we) begin
                if (qa.size() == 0) begin
                    chk("out_we_unexpected", 1, 0);
                end else begin
                    a = qa.pop_front();
                    d = qd.pop_front();
                    chk("out_addr", bus.out_addr, a);
                    chk("out_data", bus.out_data, d);
                    if (in_tile > 0) chk("write_burst_gap", n, last_we + 1);
                    in_tile = (in_tile + 1) % 4;
                    last_we = n;
                    if (a >= 0 && a < NOUT) written[a]++;
                    writes++;
                end
            end

            if (bus.done) begin
                dones++;
                chk("done_busy_low", bus.busy, 0);
                fin = 1'b1;
            end
        end

        if (!fin) chk("pass_timeout", 0, 1);
        chk("enable_count", enables, NTX*NTY);
        chk("write_count", writes, NOUT);
        chk("done_count", dones, 1);
        chk("pending_writes", qa.size(), 0);
        for (int i = 0; i < NOUT; i++) chk("addr_written_once", written[i], 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_busy", bus.busy, 0);
            chk("idle_done", bus.done, 0);
            chk("idle_fm_rd", bus.fm_rd, 0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.kernel_in = '0;
        bus.bitwidth_in = '0;
        bus.f_tmp = '0;
        bus.end_signal_win33 = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_fm_rd", bus.fm_rd, 0);
        chk("rst_fm_addr", bus.fm_addr, 0);
        chk("rst_out_we", bus.out_we, 0);
        chk("rst_out_addr", bus.out_addr, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_enable", bus.enable, 0);
        chk("rst_act", {bus.act1, bus.act2, bus.act3, bus.act4}, 0);
        chk("rst_kernel", {bus.kernel1, bus.kernel2, bus.kernel3}, 0);
        chk("rst_bitwidth", bus.bitwidth, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);

        fill_mem(1'b1);
        run_pass(3, 1'b1, 1'b0, -1);
        fill_mem(1'b0);
        run_pass(0, 1'b0, 1'b1, -1);
        fill_mem(1'b0);
        run_pass(50, 1'b0, 1'b0, -1);
        fill_mem(1'b0);
        run_pass(2, 1'b0, 1'b0, 7);
        @(negedge clk);
        run_pass(0, 1'b0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
